// File: rtl/trdb_pkg.sv
// rtl/trdb_pkg.sv - shared trace-debugger types for the instruction window
package trdb_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    RUN   = 2'd2
  } window_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] iaddr;
    logic [XLEN-1:0] inst_data;
    logic            compressed;
    logic            exception;
    logic            interrupt;
    logic            eret;
  } instr_entry_t;

endpackage

// File: rtl/trdb_instr_window_ctrl_if.sv
// rtl/trdb_instr_window_ctrl_if.sv - retired-instruction input stream and window output bundle
interface trdb_instr_window_ctrl_if #(
  parameter int XLEN = trdb_pkg::XLEN
) ();

  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] in_iaddr_i;
  logic [XLEN-1:0] in_inst_data_i;
  logic            in_compressed_i;
  logic            in_exception_i;
  logic            in_interrupt_i;
  logic            in_eret_i;

  logic            out_valid_o;
  logic            out_ready_i;
  logic            pc_valid_o;
  logic            cc_valid_o;
  logic            nc_valid_o;
  logic [XLEN-1:0] pc_iaddr_o;
  logic [XLEN-1:0] cc_iaddr_o;
  logic [XLEN-1:0] nc_iaddr_o;
  logic [XLEN-1:0] cc_inst_data_o;
  logic            cc_compressed_o;
  logic            cc_exception_o;
  logic            cc_interrupt_o;
  logic            cc_eret_o;

  modport master (
    output in_valid_i, in_iaddr_i, in_inst_data_i, in_compressed_i,
           in_exception_i, in_interrupt_i, in_eret_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_valid_o, cc_valid_o, nc_valid_o,
           pc_iaddr_o, cc_iaddr_o, nc_iaddr_o, cc_inst_data_o,
           cc_compressed_o, cc_exception_o, cc_interrupt_o, cc_eret_o
  );

  modport slave (
    input  in_valid_i, in_iaddr_i, in_inst_data_i, in_compressed_i,
           in_exception_i, in_interrupt_i, in_eret_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_valid_o, cc_valid_o, nc_valid_o,
           pc_iaddr_o, cc_iaddr_o, nc_iaddr_o, cc_inst_data_o,
           cc_compressed_o, cc_exception_o, cc_interrupt_o, cc_eret_o
  );

endinterface

// File: rtl/trdb_instr_window_ctrl.sv
// rtl/trdb_instr_window_ctrl.sv - previous/current/next sliding window feeding itype_detector
module trdb_instr_window_ctrl
  import trdb_pkg::*;
#(
  parameter int XLEN = trdb_pkg::XLEN
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  output logic                      drain_done_o,
  trdb_instr_window_ctrl_if.slave   win
);

  window_state_e state_q;
  logic          drain_q;
  instr_entry_t  p_q, c_q, n_q;
  instr_entry_t  in_entry;
  logic          in_ready, out_valid, accept, fire, drain_done;

  always_comb begin
    in_entry            = '0;
    in_entry.valid      = 1'b1;
    in_entry.iaddr      = XLEN'(win.in_iaddr_i);
    in_entry.inst_data  = XLEN'(win.in_inst_data_i);
    in_entry.compressed = win.in_compressed_i;
    in_entry.exception  = win.in_exception_i;
    in_entry.interrupt  = win.in_interrupt_i;
    in_entry.eret       = win.in_eret_i;
  end

  // In RUN a new instruction can only enter when C leaves in the same cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!drain_q) in_ready = (state_q == RUN) ? win.out_ready_i : 1'b1;
  end

  assign out_valid  = c_q.valid & (n_q.valid | drain_q);
  assign accept     = win.in_valid_i & in_ready;
  assign fire       = out_valid & win.out_ready_i;
  // Drain ends when the last C leaves, or immediately if the window was empty.
  assign drain_done = drain_q & (c_q.valid ? (fire & ~n_q.valid) : 1'b1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      drain_q <= 1'b0;
      p_q     <= '0;
      c_q     <= '0;
      n_q     <= '0;
    end else begin
      if (flush_i && !drain_q) drain_q <= 1'b1;
      if (drain_done) begin
        drain_q     <= 1'b0;
        p_q         <= '0;
        c_q.valid   <= 1'b0;
        n_q.valid   <= 1'b0;
        state_q     <= EMPTY;
      end else if (fire) begin
        p_q <= c_q;
        c_q <= n_q;
        if (accept) begin
          n_q     <= in_entry;
          state_q <= RUN;
        end else begin
          n_q.valid <= 1'b0;
          state_q   <= HALF;
        end
      end else if (accept) begin
        if (state_q == EMPTY) begin
          c_q     <= in_entry;
          state_q <= HALF;
        end else begin
          n_q     <= in_entry;
          state_q <= RUN;
        end
      end
    end
  end

  assign win.in_ready_o      = in_ready;
  assign win.out_valid_o     = out_valid;
  assign win.pc_valid_o      = p_q.valid;
  assign win.cc_valid_o      = c_q.valid;
  assign win.nc_valid_o      = n_q.valid;
  assign win.pc_iaddr_o      = p_q.iaddr;
  assign win.cc_iaddr_o      = c_q.iaddr;
  assign win.nc_iaddr_o      = n_q.iaddr;
  assign win.cc_inst_data_o  = c_q.inst_data;
  assign win.cc_compressed_o = c_q.compressed;
  assign win.cc_exception_o  = c_q.exception;
  assign win.cc_interrupt_o  = c_q.interrupt;
  assign win.cc_eret_o       = c_q.eret;
  assign drain_done_o        = drain_done;

endmodule

// File: tb/tb_trdb_instr_window_ctrl.sv
// tb/tb_trdb_instr_window_ctrl.sv - directed self-checking bench for trdb_instr_window_ctrl
module tb_trdb_instr_window_ctrl;

  logic clk;
  logic rst_n;
  logic flush;
  logic drain_done;
  int   errors = 0;
  int   checks = 0;

  trdb_instr_window_ctrl_if #(.XLEN(64)) win ();

  trdb_instr_window_ctrl #(.XLEN(64)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .drain_done_o (drain_done),
    .win          (win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic rdy, input logic fl);
    win.in_valid_i      = v;
    win.in_iaddr_i      = a;
    win.in_inst_data_i  = a ^ 64'hA5A5_0000_0000_0013;
    win.in_compressed_i = 1'b0;
    win.in_exception_i  = 1'b0;
    win.in_interrupt_i  = 1'b0;
    win.in_eret_i       = 1'b0;
    win.out_ready_i     = rdy;
    flush               = fl;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (win.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", win.out_valid_o); end
    checks++; if (win.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", win.in_ready_o); end
    checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL reset_drain_done: got %b want 0", drain_done); end
    checks++; if ({win.pc_valid_o, win.cc_valid_o, win.nc_valid_o} !== 3'b000) begin errors++; $display("FAIL reset_valids: got %b want 000", {win.pc_valid_o, win.cc_valid_o, win.nc_valid_o}); end
    checks++; if ({win.cc_iaddr_o, win.cc_inst_data_o, win.pc_iaddr_o, win.nc_iaddr_o} !== 256'h0) begin errors++; $display("FAIL reset_payload: got nonzero cc_iaddr=%h want 0", win.cc_iaddr_o); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 64'h1000, 1'b1, 1'b0);
    checks++; if (win.out_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_c0_out_valid: got %b want 0", win.out_valid_o); end
    tick();
    drive(1'b1, 64'h1004, 1'b1, 1'b0);
    checks++; if (win.out_valid_o !== 1'b0 || win.cc_iaddr_o !== 64'h1000) begin errors++; $display("FAIL b2b_c1: out_valid=%b cc=%h want 0/1000", win.out_valid_o, win.cc_iaddr_o); end
    tick();
    drive(1'b1, 64'h1008, 1'b1, 1'b0);
    checks++; if (win.out_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_c2_out_valid: got %b want 1", win.out_valid_o); end
    checks++; if (win.cc_iaddr_o !== 64'h1000 || win.nc_iaddr_o !== 64'h1004) begin errors++; $display("FAIL b2b_c2_window: cc=%h nc=%h want 1000/1004", win.cc_iaddr_o, win.nc_iaddr_o); end
    checks++; if (win.pc_valid_o !== 1'b0 || win.in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_c2_pc_ready: pc_valid=%b in_ready=%b want 0/1", win.pc_valid_o, win.in_ready_o); end
    checks++; if (win.cc_inst_data_o !== (64'h1000 ^ 64'hA5A5_0000_0000_0013)) begin errors++; $display("FAIL b2b_c2_inst_data: got %h", win.cc_inst_data_o); end
    tick();
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    checks++; if (win.cc_iaddr_o !== 64'h1004 || win.pc_iaddr_o !== 64'h1000 || win.pc_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_c3_shift: cc=%h pc=%h pc_valid=%b want 1004/1000/1", win.cc_iaddr_o, win.pc_iaddr_o, win.pc_valid_o); end
    checks++; if (win.nc_iaddr_o !== 64'h1008 || win.out_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_c3_next: nc=%h out_valid=%b want 1008/1", win.nc_iaddr_o, win.out_valid_o); end
    tick();
    checks++; if (win.nc_valid_o !== 1'b0 || win.out_valid_o !== 1'b0 || win.cc_iaddr_o !== 64'h1008) begin errors++; $display("FAIL b2b_c4_half: nc_valid=%b out_valid=%b cc=%h want 0/0/1008", win.nc_valid_o, win.out_valid_o, win.cc_iaddr_o); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 64'h100C, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 64'h1010, 1'b0, 1'b0);
      checks++; if (win.in_ready_o !== 1'b0 || win.out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold_handshake[%0d]: in_ready=%b out_valid=%b want 0/1", k, win.in_ready_o, win.out_valid_o); end
      checks++; if (win.cc_iaddr_o !== 64'h1008 || win.nc_iaddr_o !== 64'h100C || win.pc_iaddr_o !== 64'h1004 || win.pc_valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold_window[%0d]: pc=%h cc=%h nc=%h want 1004/1008/100c", k, win.pc_iaddr_o, win.cc_iaddr_o, win.nc_iaddr_o); end
      tick();
    end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    tick();
    checks++; if (win.cc_iaddr_o !== 64'h100C || win.pc_iaddr_o !== 64'h1008 || win.nc_valid_o !== 1'b0 || win.out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_release: pc=%h cc=%h nc_valid=%b out_valid=%b want 1008/100c/0/0", win.pc_iaddr_o, win.cc_iaddr_o, win.nc_valid_o, win.out_valid_o); end
  endtask

  task automatic test_flush_drain();
    do_reset();
    drive(1'b1, 64'h2000, 1'b1, 1'b0);
    tick();
    drive(1'b1, 64'h2004, 1'b1, 1'b0);
    tick();
    drive(1'b0, 64'h0, 1'b1, 1'b1);
    checks++; if (win.out_valid_o !== 1'b1 || win.cc_iaddr_o !== 64'h2000 || win.nc_iaddr_o !== 64'h2004 || drain_done !== 1'b0) begin errors++; $display("FAIL flush_fire1: out_valid=%b cc=%h nc=%h done=%b want 1/2000/2004/0", win.out_valid_o, win.cc_iaddr_o, win.nc_iaddr_o, drain_done); end
    tick();
    drive(1'b1, 64'h2008, 1'b1, 1'b0);
    checks++; if (win.out_valid_o !== 1'b1 || win.cc_iaddr_o !== 64'h2004 || win.nc_valid_o !== 1'b0) begin errors++; $display("FAIL flush_fire2: out_valid=%b cc=%h nc_valid=%b want 1/2004/0", win.out_valid_o, win.cc_iaddr_o, win.nc_valid_o); end
    checks++; if (win.in_ready_o !== 1'b0 || drain_done !== 1'b1 || win.pc_iaddr_o !== 64'h2000) begin errors++; $display("FAIL flush_fire2_ctl: in_ready=%b done=%b pc=%h want 0/1/2000", win.in_ready_o, drain_done, win.pc_iaddr_o); end
    tick();
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    checks++; if (drain_done !== 1'b0 || win.pc_valid_o !== 1'b0 || win.cc_valid_o !== 1'b0 || win.out_valid_o !== 1'b0 || win.in_ready_o !== 1'b1) begin errors++; $display("FAIL flush_after: done=%b pc_valid=%b cc_valid=%b out_valid=%b in_ready=%b want 0/0/0/0/1", drain_done, win.pc_valid_o, win.cc_valid_o, win.out_valid_o, win.in_ready_o); end
  endtask

  task automatic test_flush_empty();
    drive(1'b0, 64'h0, 1'b1, 1'b1);
    checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL fe_c0_done: got %b want 0", drain_done); end
    tick();
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    checks++; if (drain_done !== 1'b1 || win.out_valid_o !== 1'b0) begin errors++; $display("FAIL fe_c1: done=%b out_valid=%b want 1/0", drain_done, win.out_valid_o); end
    tick();
    checks++; if (drain_done !== 1'b0 || win.out_valid_o !== 1'b0 || win.in_ready_o !== 1'b1) begin errors++; $display("FAIL fe_c2: done=%b out_valid=%b in_ready=%b want 0/0/1", drain_done, win.out_valid_o, win.in_ready_o); end
  endtask

  task automatic test_exception_flags();
    do_reset();
    drive(1'b1, 64'h3000, 1'b0, 1'b0);
    win.in_exception_i  = 1'b1;
    win.in_compressed_i = 1'b1;
    win.in_eret_i       = 1'b1;
    tick();
    drive(1'b1, 64'h4000, 1'b0, 1'b0);
    win.in_interrupt_i = 1'b1;
    tick();
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    checks++; if (win.out_valid_o !== 1'b1 || win.cc_exception_o !== 1'b1 || win.cc_iaddr_o !== 64'h3000 || win.nc_iaddr_o !== 64'h4000) begin errors++; $display("FAIL exc_window: out_valid=%b exc=%b cc=%h nc=%h want 1/1/3000/4000", win.out_valid_o, win.cc_exception_o, win.cc_iaddr_o, win.nc_iaddr_o); end
    checks++; if ({win.cc_compressed_o, win.cc_interrupt_o, win.cc_eret_o} !== 3'b101) begin errors++; $display("FAIL exc_flags: c/i/e=%b want 101", {win.cc_compressed_o, win.cc_interrupt_o, win.cc_eret_o}); end
    tick();
    checks++; if (win.cc_exception_o !== 1'b0 || win.cc_interrupt_o !== 1'b1 || win.cc_iaddr_o !== 64'h4000) begin errors++; $display("FAIL exc_shift: exc=%b int=%b cc=%h want 0/1/4000", win.cc_exception_o, win.cc_interrupt_o, win.cc_iaddr_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 64'h5000, 1'b1, 1'b0);
    tick();
    drive(1'b1, 64'h5004, 1'b1, 1'b0);
    tick();
    drive(1'b1, 64'h5008, 1'b1, 1'b0);
    tick();
    checks++; if (win.pc_valid_o !== 1'b1 || win.out_valid_o !== 1'b1) begin errors++; $display("FAIL ar_pre: pc_valid=%b out_valid=%b want 1/1", win.pc_valid_o, win.out_valid_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({win.out_valid_o, win.pc_valid_o, win.cc_valid_o, win.nc_valid_o} !== 4'b0000 || win.cc_iaddr_o !== 64'h0 || win.in_ready_o !== 1'b1) begin errors++; $display("FAIL ar_async: ov/pv/cv/nv=%b cc=%h in_ready=%b want 0000/0/1", {win.out_valid_o, win.pc_valid_o, win.cc_valid_o, win.nc_valid_o}, win.cc_iaddr_o, win.in_ready_o); end
    tick();
    rst_n = 1'b1;
    drive(1'b1, 64'h6000, 1'b1, 1'b0);
    tick();
    drive(1'b1, 64'h6004, 1'b1, 1'b0);
    tick();
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    checks++; if (win.out_valid_o !== 1'b1 || win.pc_valid_o !== 1'b0 || win.cc_iaddr_o !== 64'h6000) begin errors++; $display("FAIL ar_first_fire: out_valid=%b pc_valid=%b cc=%h want 1/0/6000", win.out_valid_o, win.pc_valid_o, win.cc_iaddr_o); end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush_drain();
    test_flush_empty();
    test_exception_flags();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
